sprite_memory_writer: RTL and testbench
=======================================

// Module: sprite_memory_writer
// PURPOSE
//   Loads sprite bitmaps into the sprite memory, writing each pixel at the address the
//   pixel-side address calculator later reads.
//   A command selects a sprite slot; the block then accepts exactly SPRITE_PIXELS pixels,
//   row-major, over a valid/ready stream.
//   It issues one registered write per pixel at address = slot*SPRITE_PIXELS + line*SPRITE_W + col.
//   It sits between the host/bus loader and the write port of the sprite RAM.
// PARAMETERS
//   SIZE_ADDRESS  14   memory address width
//   COLOR_W       9    pixel data width
//   SPRITE_W      20   pixels per sprite line
//   SPRITE_PIXELS 400  pixels per sprite (SPRITE_W*SPRITE_W)
//   MAX_SPRITES   40   valid slots 0..MAX_SPRITES-1 (40*400=16000 < 16383, the unused default address)
// PORTS
//   clk             in   1             system clock, rising edge
//   reset_n         in   1             asynchronous reset, active low
//   cmd_valid       in   1             load command present
//   cmd_ready       out  1             block accepts a command
//   cmd_sprite_id   in   9             target sprite slot (same field width as sprite_datas[8:0])
//   pix_valid       in   1             pixel present on pix_data
//   pix_ready       out  1             block accepts a pixel
//   pix_data        in   COLOR_W       pixel colour
//   mem_wr_en       out  1             sprite RAM write strobe
//   mem_wr_address  out  SIZE_ADDRESS  sprite RAM write address
//   mem_wr_data     out  COLOR_W       sprite RAM write data
//   busy            out  1             high in any state other than IDLE
//   done            out  1             1-cycle pulse: last pixel written
//   error           out  1             1-cycle pulse: command rejected (id >= MAX_SPRITES)
// BEHAVIOUR
//   - Reset (async assert, sync release) forces state IDLE.
//   - Reset values: cmd_ready=1, pix_ready=0, mem_wr_en=0, mem_wr_address=16383, mem_wr_data=0,
//     busy=0, done=0, error=0. Counters are cleared.
//   - Reset mid-load discards the load. Pixels already written stay in RAM; nothing further is written.
//   - FSM IDLE: cmd_ready=1, pix_ready=0.
//     - cmd_valid&cmd_ready with id<MAX_SPRITES: base=id*SPRITE_PIXELS (registered); col=0, line=0,
//       n=0; go to LOAD.
//     - cmd_valid&cmd_ready with id>=MAX_SPRITES: error=1 next cycle; stay IDLE; no write.
//   - FSM LOAD: cmd_ready=0, pix_ready=1. Each pix_valid&pix_ready cycle is one accepted pixel.
//     - Next cycle: mem_wr_en=1, mem_wr_address=base+line*SPRITE_W+col, mem_wr_data=pix_data.
//       Latency is 1 clock; one write per accepted pixel.
//     - The address is a running counter (base+n). It must equal the line/col formula.
//     - col increments and wraps SPRITE_W-1 -> 0 with line+1. n increments 0..SPRITE_PIXELS-1.
//     - Cycles without pix_valid: no write, counters hold. Gaps of any length are legal.
//     - Pixel n=SPRITE_PIXELS-1 accepted: go to DONE. pix_ready drops in the same edge,
//       so no pixel 400 is accepted.
//   - FSM DONE (1 cycle): done=1 aligned with the final write. Return to IDLE.
//     cmd_ready re-asserts the next cycle.
//   - cmd_valid during LOAD/DONE is ignored (cmd_ready=0). The command must be held until accepted.
//   - mem_wr_en=0 cycles hold mem_wr_address/mem_wr_data at their last values. Only mem_wr_en qualifies.
//   - Arithmetic: all address math is SIZE_ADDRESS wide and zero-extended. Max address = 15999; no overflow.
// CONFIGURATION
//   SPRITE_WRITER_SKIP_TRANSP_EN
//     - Defined: a pixel equal to all-ones (transparent key) is accepted and advances the
//       counters, but mem_wr_en stays 0 for it. The RAM keeps its prior contents there.
//     - Undefined: every accepted pixel is written, including all-ones.
//     - done timing and pixel count are identical in both builds.
// TESTING
//   - id=0, 400 back-to-back pixels (data=n) -> writes addr 0..399, data 0..399 (mod 2^9), done at addr 399, error=0.
//   - id=3, pixel n=21 -> write addr 1221 (line1 col1); first write 1200, last 1599; busy high throughout load.
//   - id=39, full load -> last write addr 15999, done pulse; then id=40 -> error pulse 1 cycle, no mem_wr_en, busy=0.
//   - id=1, pix_valid toggled randomly (50%) -> exactly 400 writes, addr 400..799 strictly +1, no writes in gaps.
//   - reset_n low after 150 pixels of id=2 -> outputs at reset values immediately; next cmd id=2 restarts at addr 800.
//   - SKIP_TRANSP_EN defined, id=0, pixel 5 = 9'h1FF -> no write at addr 5, addr 6 written next; total 399 writes; done unchanged.

Source files
------------

// File: rtl/sprite_memory_writer.sv
// Streams one sprite bitmap into the sprite RAM at slot*SPRITE_PIXELS + line*SPRITE_W + col.
// Optional build macro SPRITE_WRITER_SKIP_TRANSP_EN: all-ones (transparent) pixels are consumed but not written.
module sprite_memory_writer #(
  parameter int SIZE_ADDRESS  = 14,
  parameter int COLOR_W       = 9,
  parameter int SPRITE_W      = 20,
  parameter int SPRITE_PIXELS = 400,
  parameter int MAX_SPRITES   = 40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [8:0]              cmd_sprite_id,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [COLOR_W-1:0]      pix_data,
  output logic                    mem_wr_en,
  output logic [SIZE_ADDRESS-1:0] mem_wr_address,
  output logic [COLOR_W-1:0]      mem_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int CW = $clog2(SPRITE_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [SIZE_ADDRESS-1:0] addr_q, addr_d;
  logic [CW-1:0]           col_q, col_d;
  logic [CW-1:0]           line_q, line_d;
  logic                    wr_en_q, wr_en_d;
  logic [SIZE_ADDRESS-1:0] wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0]      wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    pix_wr;
  logic                    last_pix;

`ifdef SPRITE_WRITER_SKIP_TRANSP_EN
  assign pix_wr = (pix_data != '1);
`else
  assign pix_wr = 1'b1;
`endif

  assign last_pix = (line_q == CW'(SPRITE_W - 1)) && (col_q == CW'(SPRITE_W - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    line_d    = line_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_sprite_id < 9'(MAX_SPRITES)) begin
            // Slot base; id is range-checked so the product fits the address width.
            addr_d  = SIZE_ADDRESS'(cmd_sprite_id) * SIZE_ADDRESS'(SPRITE_PIXELS);
            col_d   = '0;
            line_d  = '0;
            state_d = S_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (pix_valid) begin
          if (pix_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pix_data;
          end
          addr_d = addr_q + SIZE_ADDRESS'(1);
          if (col_q == CW'(SPRITE_W - 1)) begin
            col_d  = '0;
            line_d = line_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_pix) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      col_q     <= '0;
      line_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '1;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      line_q    <= line_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign pix_ready      = (state_q == S_LOAD);
  assign busy           = (state_q != S_IDLE);
  assign mem_wr_en      = wr_en_q;
  assign mem_wr_address = wr_addr_q;
  assign mem_wr_data    = wr_data_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_sprite_memory_writer.sv
// Directed bench for sprite_memory_writer; expectations follow the slot/line/col address formula.
module tb_sprite_memory_writer;

`ifdef SPRITE_WRITER_SKIP_TRANSP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_sprite_id;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_data;
  logic        mem_wr_en;
  logic [13:0] mem_wr_address;
  logic [8:0]  mem_wr_data;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int last_addr = 16383;
  int last_data = 0;

  sprite_memory_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_sprite_id  (cmd_sprite_id),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_address (mem_wr_address),
    .mem_wr_data    (mem_wr_data),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_address), 32'd16383);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  // Loads slot id; trans_n marks the pixel carrying 9'h1FF (-1: none); stop_at < 400 abandons the load.
  task automatic load(input int id, input bit gaps, input bit noise, input int trans_n, input int stop_at);
    int n = 0;
    int cyc = 0;
    int wcnt = 0;
    int ea;
    logic [8:0] d;
    bit exp_en;
    cmd_valid = 1'b1;
    cmd_sprite_id = 9'(id);
    step();
    chk("cmd_accept_busy", 32'(busy), 32'd1);
    chk("cmd_accept_pix_ready", 32'(pix_ready), 32'd1);
    chk("cmd_accept_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    while (n < stop_at) begin
      cyc++;
      if (cyc > 3000) begin
        chk("load_cycle_budget", 32'(n), 32'(stop_at));
        break;
      end
      if (noise) begin
        cmd_valid = 1'b1;
        cmd_sprite_id = 9'd7;
      end
      if (gaps && $urandom_range(1) == 0) begin
        pix_valid = 1'b0;
        step();
        if (mem_wr_en) wcnt++;
        chk("gap_no_write", 32'(mem_wr_en), 32'd0);
        chk("gap_addr_hold", 32'(mem_wr_address), 32'(last_addr));
        chk("gap_busy", 32'(busy), 32'd1);
        continue;
      end
      d = (n == trans_n) ? 9'h1FF : 9'(n);
      pix_valid = 1'b1;
      pix_data = d;
      step();
      if (mem_wr_en) wcnt++;
      exp_en = !(SKIP && d == 9'h1FF);
      ea = id * 400 + (n / 20) * 20 + (n % 20);
      chk("pix_wr_en", 32'(mem_wr_en), 32'(exp_en));
      if (exp_en) begin
        chk("pix_addr", 32'(mem_wr_address), 32'(ea));
        chk("pix_data", 32'(mem_wr_data), 32'(d));
        last_addr = ea;
        last_data = int'(d);
      end else begin
        chk("skip_addr_hold", 32'(mem_wr_address), 32'(last_addr));
        chk("skip_data_hold", 32'(mem_wr_data), 32'(last_data));
      end
      chk("pix_busy", 32'(busy), 32'd1);
      chk("pix_done", 32'(done), 32'(n == 399));
      if (id == 3 && n == 21) chk("id3_line1_col1", 32'(mem_wr_address), 32'd1221);
      n++;
    end
    pix_valid = 1'b0;
    cmd_valid = 1'b0;
    if (stop_at == 400) begin
      step();
      chk("post_done_low", 32'(done), 32'd0);
      chk("post_busy_low", 32'(busy), 32'd0);
      chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_pix_ready", 32'(pix_ready), 32'd0);
      chk("post_no_write", 32'(mem_wr_en), 32'd0);
      chk("post_addr_hold", 32'(mem_wr_address), 32'(last_addr));
      chk("write_count", 32'(wcnt), 32'((SKIP && trans_n >= 0) ? 399 : 400));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_sprite_id = '0;
    pix_valid = 1'b0;
    pix_data = '0;
    step();
    chk_reset_vals();
    step();
    reset_n = 1'b1;
    step();
    chk_reset_vals();

    // id 0: back-to-back, data = n
    load(0, 1'b0, 1'b0, -1, 400);
    chk("id0_last_addr", 32'(mem_wr_address), 32'd399);
    chk("id0_no_error", 32'(error), 32'd0);

    // id 3: first 1200, 1221 at n=21, last 1599
    load(3, 1'b0, 1'b0, -1, 400);
    chk("id3_last_addr", 32'(mem_wr_address), 32'd1599);

    // id 39 then out-of-range id 40
    load(39, 1'b0, 1'b0, -1, 400);
    chk("id39_last_addr", 32'(mem_wr_address), 32'd15999);
    cmd_valid = 1'b1;
    cmd_sprite_id = 9'd40;
    step();
    chk("err_pulse", 32'(error), 32'd1);
    chk("err_no_write", 32'(mem_wr_en), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("err_addr_hold", 32'(mem_wr_address), 32'd15999);
    cmd_valid = 1'b0;
    step();
    chk("err_one_cycle", 32'(error), 32'd0);
    chk("err_still_idle", 32'(pix_ready), 32'd0);

    // id 1: random gaps, command noise held during the load
    load(1, 1'b1, 1'b1, -1, 400);
    chk("id1_last_addr", 32'(mem_wr_address), 32'd799);

    // id 2: reset after 150 pixels, then full reload
    load(2, 1'b0, 1'b0, -1, 150);
    chk("id2_partial_addr", 32'(mem_wr_address), 32'd949);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    last_addr = 16383;
    last_data = 0;
    step();
    reset_n = 1'b1;
    step();
    chk_reset_vals();
    load(2, 1'b0, 1'b0, -1, 400);
    chk("id2_last_addr", 32'(mem_wr_address), 32'd1199);

    // id 0 with transparent key at pixel 5
    load(0, 1'b0, 1'b0, 5, 400);
    chk("transp_last_addr", 32'(mem_wr_address), 32'd399);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
